// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite encodings (HTRANS, HSIZE, HRESP) and the data-phase state
// machine encoding used by the data_mem_ahb2 SRAM slave.
// ---------------------------------------------------------------------------
package ahb_pkg;

    // Transfer type carried on HTRANS during the address phase.
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    // Transfer size carried on HSIZE (log2 of the number of bytes).
    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_e;

    // Slave response.
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Data-phase state of the slave.
    //   ST_IDLE   : no data phase in progress, zero-wait OKAY
    //   ST_WAIT   : configurable stall cycles before the SRAM access
    //   ST_ACCESS : SRAM enabled (write completes here, read is issued here)
    //   ST_RDATA  : SRAM read data presented on the bus
    //   ST_ERR1   : first cycle of the two-cycle ERROR response
    //   ST_ERR2   : second cycle of the two-cycle ERROR response
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RDATA  = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_e;

endpackage : ahb_pkg

// File: rtl/sram_sp_be.sv
// ---------------------------------------------------------------------------
// sram_sp_be
// Single-port synchronous SRAM with per-byte write enables. Each byte lane is
// its own array so every lane maps cleanly onto a block RAM column.
//
// Ports
//   clk_i    : clock
//   en_i     : port enable (read or write this cycle)
//   we_i     : 1 = write the lanes selected by be_i, 0 = read
//   be_i     : per-byte write enables, bit n covers wdata_i[8n+7:8n]
//   addr_i   : word address
//   wdata_i  : write data
//   rdata_o  : read data, valid the cycle after a read is issued; holds
//              its value across writes and idle cycles
// ---------------------------------------------------------------------------
module sram_sp_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk_i,
    input  logic                    en_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];
            logic [7:0] rdata_q;

            always_ff @(posedge clk_i) begin
                if (en_i) begin
                    if (we_i) begin
                        if (be_i[gi]) begin
                            mem_lane[addr_i] <= wdata_i[8*gi +: 8];
                        end
                    end else begin
                        rdata_q <= mem_lane[addr_i];
                    end
                end
            end

            assign rdata_o[8*gi +: 8] = rdata_q;
        end
    endgenerate

endmodule : sram_sp_be

// File: rtl/data_mem_ahb2.sv
// ---------------------------------------------------------------------------
// data_mem_ahb2
// AHB-Lite slave fronting a single-port byte-enabled SRAM. Supports
// configurable data-phase wait states, a two-cycle ERROR response for
// out-of-range, misaligned or oversized transfers, and pipelined
// back-to-back transfers.
//
// Parameters
//   DATA_WIDTH  : bus width, 32 or 64
//   ADDR_WIDTH  : SRAM word-address width (depth 2^ADDR_WIDTH words)
//   BASE_ADDR   : byte base address, aligned to the region size
//   WAIT_STATES : extra stall cycles per data phase, 0..3
//
// Ports
//   hclk_i    : clock
//   hreset_i  : synchronous active-high reset
//   hsel_i    : slave select
//   haddr_i   : byte address (address phase)
//   htrans_i  : transfer type
//   hwrite_i  : 1 = write, 0 = read
//   hsize_i   : transfer size
//   hready_i  : bus HREADY, address phase accepted only when high
//   hwdata_i  : write data (data phase)
//   hrdata_o  : read data
//   hready_o  : data-phase completion
//   hresp_o   : 0 OKAY, 1 ERROR
// ---------------------------------------------------------------------------
module data_mem_ahb2
    import ahb_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                  hclk_i,
    input  logic                  hreset_i,
    input  logic                  hsel_i,
    input  logic [31:0]           haddr_i,
    input  logic [1:0]            htrans_i,
    input  logic                  hwrite_i,
    input  logic [2:0]            hsize_i,
    input  logic                  hready_i,
    input  logic [DATA_WIDTH-1:0] hwdata_i,
    output logic [DATA_WIDTH-1:0] hrdata_o,
    output logic                  hready_o,
    output logic                  hresp_o
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);        // byte-offset bits within a word
    localparam int RGN = ADDR_WIDTH + OFF;  // byte-address bits inside the region

    // ------------------------------------------------------------------
    // State and captured address-phase controls
    // ------------------------------------------------------------------
    state_e                state_q, state_d;
    logic [1:0]            wait_cnt_q, wait_cnt_d;
    logic [RGN-1:0]        addr_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic [DATA_WIDTH-1:0] hrdata_q;

    // Internal (pre-reset-gating) outputs of the FSM
    logic                  ready_int;
    logic                  resp_int;

    logic                  accept;
    logic                  req_err;
    logic [31:0]           size_mask;

    // SRAM side
    logic                  sram_en;
    logic                  sram_we;
    logic [NB-1:0]         sram_be;
    logic [DATA_WIDTH-1:0] sram_rdata;
    int                    lane_idx;
    int                    nbytes;

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    // Only NONSEQ/SEQ start a data phase; IDLE/BUSY fall through to the
    // zero-wait OKAY of ST_IDLE. The slave's own hready is included so a
    // new address is only taken when the current data phase is completing.
    assign accept = hsel_i && hready_i && ready_int &&
                    ((htrans_i == HTRANS_NONSEQ) || (htrans_i == HTRANS_SEQ));

    always_comb begin
        size_mask = (32'd1 << hsize_i) - 32'd1;
        req_err   = 1'b0;
        // Region is aligned to its size, so an upper-bit compare is a
        // full range check.
        if (haddr_i[31:RGN] != BASE_ADDR[31:RGN]) begin
            req_err = 1'b1;
        end
        if (int'(hsize_i) > OFF) begin
            req_err = 1'b1;
        end
        if ((haddr_i & size_mask) != 32'd0) begin
            req_err = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;

        // Completion cycles may pick up the next address phase directly,
        // which is what makes back-to-back transfers gap-free.
        if (accept) begin
            if (req_err) begin
                state_d = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d    = ST_WAIT;
                wait_cnt_d = 2'(WAIT_STATES - 1);
            end else begin
                state_d = ST_ACCESS;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_WAIT: begin
                    if (wait_cnt_q == 2'd0) begin
                        state_d = ST_ACCESS;
                    end else begin
                        wait_cnt_d = wait_cnt_q - 2'd1;
                    end
                end
                ST_ACCESS: begin
                    // A write completes here; a read needs one more cycle
                    // for the synchronous SRAM output.
                    state_d = write_q ? ST_IDLE : ST_RDATA;
                end
                ST_RDATA: begin
                    state_d = ST_IDLE;
                end
                ST_ERR1: begin
                    state_d = ST_ERR2;
                end
                ST_ERR2: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        ready_int = 1'b1;
        resp_int  = HRESP_OKAY;
        sram_en   = 1'b0;
        sram_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_int = 1'b1;
            end
            ST_WAIT: begin
                ready_int = 1'b0;
            end
            ST_ACCESS: begin
                sram_en   = 1'b1;
                sram_we   = write_q;
                ready_int = write_q;
            end
            ST_RDATA: begin
                ready_int = 1'b1;
            end
            ST_ERR1: begin
                resp_int  = HRESP_ERROR;
                ready_int = 1'b0;
            end
            ST_ERR2: begin
                resp_int  = HRESP_ERROR;
                ready_int = 1'b1;
            end
            default: begin
                ready_int = 1'b1;
            end
        endcase

        // Reset overrides the bus outputs immediately and blocks any SRAM
        // write, so a write caught by reset is never committed.
        if (hreset_i) begin
            hready_o = 1'b1;
            hresp_o  = HRESP_OKAY;
            hrdata_o = '0;
            sram_en  = 1'b0;
            sram_we  = 1'b0;
        end else begin
            hready_o = ready_int;
            hresp_o  = resp_int;
            hrdata_o = (state_q == ST_RDATA) ? sram_rdata : hrdata_q;
        end
    end

    // ------------------------------------------------------------------
    // Address-phase capture and read-data hold register
    // ------------------------------------------------------------------
    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
            hrdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= haddr_i[RGN-1:0];
                write_q <= hwrite_i;
                size_q  <= hsize_i;
            end
            // Keeps hrdata_o stable after the read data phase ends.
            if (state_q == ST_RDATA) begin
                hrdata_q <= sram_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte enables: a run of 2^size lanes starting at the byte offset.
    // Only used in ST_ACCESS, where size/offset are known to be legal.
    // ------------------------------------------------------------------
    always_comb begin
        sram_be  = '0;
        lane_idx = int'(addr_q[OFF-1:0]);
        nbytes   = 1 << size_q;
        for (int b = 0; b < NB; b++) begin
            if ((b >= lane_idx) && (b < lane_idx + nbytes)) begin
                sram_be[b] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    sram_sp_be #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram (
        .clk_i   (hclk_i),
        .en_i    (sram_en),
        .we_i    (sram_we),
        .be_i    (sram_be),
        .addr_i  (addr_q[RGN-1:OFF]),
        .wdata_i (hwdata_i),
        .rdata_o (sram_rdata)
    );

endmodule : data_mem_ahb2

// File: tb/tb_data_mem_ahb2.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ahb2
// Two slave instances share one AHB master: dut0 with zero wait states and
// dut2 with two. use2 selects which one the master addresses; the bus HREADY
// is the selected slave's hready_o.
// ---------------------------------------------------------------------------
module tb_data_mem_ahb2;

    localparam int          DW   = 32;
    localparam int          AW   = 10;
    localparam logic [31:0] BASE = 32'h0001_0000;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          hreset;
    logic          hsel;
    logic [31:0]   haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [DW-1:0] hwdata;
    logic          use2;

    logic          hready0, hresp0, hready2, hresp2;
    logic [DW-1:0] hrdata0, hrdata2;
    logic          hready, hresp;
    logic [DW-1:0] hrdata;

    assign hready = use2 ? hready2 : hready0;
    assign hresp  = use2 ? hresp2  : hresp0;
    assign hrdata = use2 ? hrdata2 : hrdata0;

    data_mem_ahb2 #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(0)
    ) dut0 (
        .hclk_i(clk), .hreset_i(hreset), .hsel_i(hsel & ~use2), .haddr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hready_i(hready),
        .hwdata_i(hwdata), .hrdata_o(hrdata0), .hready_o(hready0), .hresp_o(hresp0)
    );

    data_mem_ahb2 #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(2)
    ) dut2 (
        .hclk_i(clk), .hreset_i(hreset), .hsel_i(hsel & use2), .haddr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hready_i(hready),
        .hwdata_i(hwdata), .hrdata_o(hrdata2), .hready_o(hready2), .hresp_o(hresp2)
    );

    typedef struct {
        logic          wr;
        logic [31:0]   addr;
        logic [2:0]    size;
        logic [DW-1:0] data;
    } req_t;

    typedef struct {
        logic [DW-1:0] data;
        int            stalls;
        int            resp_cycles;
        int            done_cyc;
    } res_t;

    typedef struct {
        logic          chk_data;
        logic [DW-1:0] data;
        int            stalls;
        int            resp_cycles;
    } exp_t;

    req_t req_q[$];
    res_t res_q[$];
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Queue one transfer together with its expected outcome.
    task automatic push(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [DW-1:0] data, input logic chk,
                        input logic [DW-1:0] exp_data, input int stalls, input int resp_cycles);
        req_t rq;
        exp_t ex;
        rq.wr = wr; rq.addr = addr; rq.size = size; rq.data = data;
        ex.chk_data = chk; ex.data = exp_data; ex.stalls = stalls; ex.resp_cycles = resp_cycles;
        req_q.push_back(rq);
        exp_q.push_back(ex);
    endtask

    // Pipelined AHB master: issues every queued request back-to-back and
    // records one result per completed data phase. Entered just after a
    // rising edge with the bus idle.
    task automatic run_bus();
        int   idx   = 0;
        bit   pend  = 0;
        int   guard = 0;
        req_t cur;
        res_t r;
        cur = '{wr: 1'b0, addr: 32'd0, size: 3'd0, data: '0};
        r   = '{data: '0, stalls: 0, resp_cycles: 0, done_cyc: 0};
        while (idx < req_q.size() || pend) begin
            if (idx < req_q.size()) begin
                hsel   = 1'b1;
                htrans = 2'b10;
                haddr  = req_q[idx].addr;
                hwrite = req_q[idx].wr;
                hsize  = req_q[idx].size;
            end else begin
                hsel   = 1'b0;
                htrans = 2'b00;
            end
            if (pend && cur.wr) hwdata = cur.data;
            @(negedge clk);
            if (pend) begin
                if (!hready) r.stalls++;
                if (hresp)   r.resp_cycles++;
            end
            if (hready) begin
                if (pend) begin
                    r.data     = hrdata;
                    r.done_cyc = cyc;
                    res_q.push_back(r);
                    pend = 0;
                end
                if (idx < req_q.size()) begin
                    cur  = req_q[idx];
                    idx++;
                    pend = 1;
                    r    = '{data: '0, stalls: 0, resp_cycles: 0, done_cyc: 0};
                end
            end
            @(posedge clk);
            #1;
            guard++;
            if (guard > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL bus_timeout: got no completion after %0d cycles, required < 200", guard);
                break;
            end
        end
        hsel   = 1'b0;
        htrans = 2'b00;
        req_q.delete();
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (hready0 !== 1'b1 || hresp0 !== 1'b0 || hrdata0 !== '0) begin
            n_fail++;
            $display("FAIL reset_dut0: got rdy=%b resp=%b rdata=%h, required rdy=1 resp=0 rdata=0",
                     hready0, hresp0, hrdata0);
        end
        n_checks++;
        if (hready2 !== 1'b1 || hresp2 !== 1'b0 || hrdata2 !== '0) begin
            n_fail++;
            $display("FAIL reset_dut2: got rdy=%b resp=%b rdata=%h, required rdy=1 resp=0 rdata=0",
                     hready2, hresp2, hrdata2);
        end
        hreset = 1'b0;
        @(posedge clk);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_word_rw();
        int d[2];
        int k = 0;
        use2 = 1'b0;
        push(1'b1, BASE, 3'd2, 32'hDEADBEEF, 1'b0, '0, 0, 0);
        push(1'b0, BASE, 3'd2, '0, 1'b1, 32'hDEADBEEF, 1, 0);
        run_bus();
        while (exp_q.size() > 0) begin
            exp_t e;
            res_t r;
            e = exp_q.pop_front();
            n_checks++;
            if (res_q.size() == 0) begin
                n_fail++;
                $display("FAIL word_rw_missing: got no result, required one");
                continue;
            end
            r = res_q.pop_front();
            if (k < 2) d[k] = r.done_cyc;
            k++;
            if (r.stalls !== e.stalls) begin
                n_fail++;
                $display("FAIL word_rw_stalls: got %0d, required %0d", r.stalls, e.stalls);
            end
            n_checks++;
            if (r.resp_cycles !== e.resp_cycles) begin
                n_fail++;
                $display("FAIL word_rw_resp: got %0d error cycles, required %0d", r.resp_cycles, e.resp_cycles);
            end
            if (e.chk_data) begin
                n_checks++;
                if (r.data !== e.data) begin
                    n_fail++;
                    $display("FAIL word_rw_data: got %h, required %h", r.data, e.data);
                end
            end
        end
        n_checks++;
        if (d[1] - d[0] != 2) begin
            n_fail++;
            $display("FAIL word_rw_gap: got %0d cycles between completions, required 2", d[1] - d[0]);
        end
        $display("test_word_rw done");
    endtask

    task automatic test_idle_busy();
        use2   = 1'b0;
        hsel   = 1'b1;
        haddr  = BASE;
        hwrite = 1'b1;
        hsize  = 3'd2;
        hwdata = 32'h0BAD0BAD;
        for (int i = 0; i < 6; i++) begin
            htrans = (i % 2 == 0) ? 2'b00 : 2'b01;
            @(negedge clk);
            n_checks++;
            if (hready0 !== 1'b1 || hresp0 !== 1'b0 || dut0.sram_en !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_busy_%0d: got rdy=%b resp=%b en=%b, required rdy=1 resp=0 en=0",
                         i, hready0, hresp0, dut0.sram_en);
            end
            @(posedge clk);
            #1;
        end
        hsel   = 1'b0;
        htrans = 2'b00;
        push(1'b0, BASE, 3'd2, '0, 1'b1, 32'hDEADBEEF, 1, 0);
        run_bus();
        while (exp_q.size() > 0) begin
            exp_t e;
            res_t r;
            e = exp_q.pop_front();
            n_checks++;
            if (res_q.size() == 0) begin
                n_fail++;
                $display("FAIL idle_busy_missing: got no result, required one");
                continue;
            end
            r = res_q.pop_front();
            if (r.data !== e.data) begin
                n_fail++;
                $display("FAIL idle_busy_mem: got %h, required %h", r.data, e.data);
            end
        end
        $display("test_idle_busy done");
    endtask

    task automatic test_byte_merge();
        use2 = 1'b0;
        push(1'b1, BASE + 32'h8, 3'd2, 32'h11223344, 1'b0, '0, 0, 0);
        push(1'b1, BASE + 32'hB, 3'd0, 32'hAA000000, 1'b0, '0, 0, 0);
        push(1'b0, BASE + 32'h8, 3'd2, '0, 1'b1, 32'hAA223344, 1, 0);
        push(1'b1, BASE + 32'hC, 3'd2, 32'h55667788, 1'b0, '0, 0, 0);
        push(1'b1, BASE + 32'hC, 3'd1, 32'hFFFF1234, 1'b0, '0, 0, 0);
        push(1'b0, BASE + 32'hC, 3'd2, '0, 1'b1, 32'h55661234, 1, 0);
        run_bus();
        while (exp_q.size() > 0) begin
            exp_t e;
            res_t r;
            e = exp_q.pop_front();
            n_checks++;
            if (res_q.size() == 0) begin
                n_fail++;
                $display("FAIL byte_merge_missing: got no result, required one");
                continue;
            end
            r = res_q.pop_front();
            if (r.stalls !== e.stalls) begin
                n_fail++;
                $display("FAIL byte_merge_stalls: got %0d, required %0d", r.stalls, e.stalls);
            end
            if (e.chk_data) begin
                n_checks++;
                if (r.data !== e.data) begin
                    n_fail++;
                    $display("FAIL byte_merge_data: got %h, required %h", r.data, e.data);
                end
            end
        end
        $display("test_byte_merge done");
    endtask

    task automatic test_errors();
        use2 = 1'b0;
        push(1'b0, BASE + 32'h2,    3'd2, '0, 1'b0, '0, 1, 2);   // misaligned read
        push(1'b0, BASE - 32'h4,    3'd2, '0, 1'b0, '0, 1, 2);   // below region
        push(1'b1, BASE + 32'h2,    3'd2, 32'h0, 1'b0, '0, 1, 2); // misaligned write
        push(1'b1, BASE,            3'd3, 32'h0, 1'b0, '0, 1, 2); // size too large
        push(1'b1, BASE + 32'h1000, 3'd2, 32'h0, 1'b0, '0, 1, 2); // one past the top
        push(1'b1, BASE + 32'hFFC,  3'd2, 32'hA5A5C3C3, 1'b0, '0, 0, 0); // last word
        push(1'b0, BASE + 32'hFFC,  3'd2, '0, 1'b1, 32'hA5A5C3C3, 1, 0);
        push(1'b0, BASE,            3'd2, '0, 1'b1, 32'hDEADBEEF, 1, 0);
        run_bus();
        while (exp_q.size() > 0) begin
            exp_t e;
            res_t r;
            e = exp_q.pop_front();
            n_checks++;
            if (res_q.size() == 0) begin
                n_fail++;
                $display("FAIL errors_missing: got no result, required one");
                continue;
            end
            r = res_q.pop_front();
            if (r.stalls !== e.stalls) begin
                n_fail++;
                $display("FAIL errors_stalls: got %0d, required %0d", r.stalls, e.stalls);
            end
            n_checks++;
            if (r.resp_cycles !== e.resp_cycles) begin
                n_fail++;
                $display("FAIL errors_resp: got %0d error cycles, required %0d", r.resp_cycles, e.resp_cycles);
            end
            if (e.chk_data) begin
                n_checks++;
                if (r.data !== e.data) begin
                    n_fail++;
                    $display("FAIL errors_data: got %h, required %h", r.data, e.data);
                end
            end
        end
        $display("test_errors done");
    endtask

    task automatic test_back_to_back();
        int d[4];
        int k = 0;
        use2 = 1'b1;
        push(1'b1, BASE + 32'h20, 3'd2, 32'hCAFEF00D, 1'b0, '0, 2, 0);
        push(1'b0, BASE + 32'h20, 3'd2, '0, 1'b1, 32'hCAFEF00D, 3, 0);
        push(1'b1, BASE + 32'h24, 3'd2, 32'h0BADF00D, 1'b0, '0, 2, 0);
        push(1'b0, BASE + 32'h24, 3'd2, '0, 1'b1, 32'h0BADF00D, 3, 0);
        run_bus();
        while (exp_q.size() > 0) begin
            exp_t e;
            res_t r;
            e = exp_q.pop_front();
            n_checks++;
            if (res_q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_missing: got no result, required one");
                continue;
            end
            r = res_q.pop_front();
            if (k < 4) d[k] = r.done_cyc;
            k++;
            if (r.stalls !== e.stalls) begin
                n_fail++;
                $display("FAIL b2b_stalls: got %0d, required %0d", r.stalls, e.stalls);
            end
            if (e.chk_data) begin
                n_checks++;
                if (r.data !== e.data) begin
                    n_fail++;
                    $display("FAIL b2b_data: got %h, required %h", r.data, e.data);
                end
            end
        end
        // Gap-free pipelining: each completion follows the previous one by
        // exactly the next transfer's data-phase length.
        n_checks++;
        if (d[1] - d[0] != 4 || d[2] - d[1] != 3 || d[3] - d[2] != 4) begin
            n_fail++;
            $display("FAIL b2b_gap: got spacing %0d/%0d/%0d, required 4/3/4",
                     d[1] - d[0], d[2] - d[1], d[3] - d[2]);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_abort();
        use2 = 1'b1;
        push(1'b1, BASE + 32'h40, 3'd2, 32'h0, 1'b0, '0, 2, 0);
        run_bus();
        // Start a write, then reset during its first wait cycle.
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = BASE + 32'h40;
        hwrite = 1'b1;
        hsize  = 3'd2;
        @(posedge clk);
        #1;
        hsel   = 1'b0;
        htrans = 2'b00;
        hwdata = 32'h12345678;
        @(negedge clk);
        n_checks++;
        if (hready2 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_wait: got rdy=%b, required 0", hready2);
        end
        hreset = 1'b1;
        #1;
        n_checks++;
        if (hready2 !== 1'b1 || hresp2 !== 1'b0 || hrdata2 !== '0) begin
            n_fail++;
            $display("FAIL abort_in_reset: got rdy=%b resp=%b rdata=%h, required 1/0/0",
                     hready2, hresp2, hrdata2);
        end
        @(posedge clk);
        #1;
        hreset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (hready2 !== 1'b1 || hresp2 !== 1'b0 || hrdata2 !== '0) begin
            n_fail++;
            $display("FAIL abort_after_reset: got rdy=%b resp=%b rdata=%h, required 1/0/0",
                     hready2, hresp2, hrdata2);
        end
        @(posedge clk);
        #1;
        push(1'b0, BASE + 32'h40, 3'd2, '0, 1'b1, 32'h0, 3, 0);
        run_bus();
        while (exp_q.size() > 0) begin
            exp_t e;
            res_t r;
            e = exp_q.pop_front();
            n_checks++;
            if (res_q.size() == 0) begin
                n_fail++;
                $display("FAIL abort_missing: got no result, required one");
                continue;
            end
            r = res_q.pop_front();
            if (r.stalls !== e.stalls) begin
                n_fail++;
                $display("FAIL abort_stalls: got %0d, required %0d", r.stalls, e.stalls);
            end
            if (e.chk_data) begin
                n_checks++;
                if (r.data !== e.data) begin
                    n_fail++;
                    $display("FAIL abort_data: got %h, required %h", r.data, e.data);
                end
            end
        end
        $display("test_reset_abort done");
    endtask

    initial begin
        hreset = 1'b1;
        hsel   = 1'b0;
        haddr  = 32'd0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'd0;
        hwdata = '0;
        use2   = 1'b0;
        test_reset();
        test_word_rw();
        test_idle_busy();
        test_byte_merge();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000 time units, required earlier");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_data_mem_ahb2

// File: doc/data_mem_ahb2.md
DATA_MEM_AHB2 -- requirements
Module: data_mem_ahb2

Interface
REQ-001 Parameter DATA_WIDTH, default 32, bus data width; legal values are 32 and 64.
REQ-002 Parameter ADDR_WIDTH, default 10, SRAM word-address width; depth is 2^ADDR_WIDTH words.
REQ-003 Parameter BASE_ADDR, default 32'h0001_0000, byte base address of the region; must be aligned to the region size.
REQ-004 Parameter WAIT_STATES, default 0, extra data-phase stall cycles per access, range 0..3.
REQ-005 hclk_i  in  1  sole clock; all state updates on its rising edge.
REQ-006 hreset_i  in  1  reset, synchronous, active-high.
REQ-007 hsel_i  in  1  slave select.
REQ-008 haddr_i  in  32  byte address, address phase.
REQ-009 htrans_i  in  2  transfer type: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
REQ-010 hwrite_i  in  1  1 = write, 0 = read.
REQ-011 hsize_i  in  3  transfer size: 0 byte, 1 half, 2 word, 3 dword (only when DATA_WIDTH=64).
REQ-012 hready_i  in  1  bus-level HREADY; an address phase is accepted only when it is high.
REQ-013 hwdata_i  in  DATA_WIDTH  write data, data phase.
REQ-014 hrdata_o  out  DATA_WIDTH  read data, valid when hready_o=1 in a read data phase.
REQ-015 hready_o  out  1  data-phase completion.
REQ-016 hresp_o  out  1  0 OKAY, 1 ERROR.

Function
REQ-017 Accept an address phase when hsel_i & htrans_i[1] & hready_i; register the address, hwrite_i and hsize_i.
REQ-018 IDLE and BUSY transfers get a zero-wait OKAY response (hready_o=1, hresp_o=0), with no SRAM access.
REQ-019 FSM states: IDLE, WAIT, ACCESS, RDATA, ERR1, ERR2; encoded per the package enum.
REQ-020 A transfer is an error if it meets any of these: address outside [BASE_ADDR, BASE_ADDR + 2^ADDR_WIDTH*DATA_WIDTH/8); address misaligned to its hsize; hsize greater than log2(DATA_WIDTH/8).
REQ-021 Error response: ERR1 drives hresp_o=1, hready_o=0; ERR2 drives hresp_o=1, hready_o=1; there is no SRAM access.
REQ-022 Valid transfer: WAIT lasts WAIT_STATES cycles with hready_o=0, then ACCESS.
REQ-023 Write: ACCESS asserts the SRAM write with byte enables from hsize and the low address bits, and drives hready_o=1.
REQ-024 Write data phase length is WAIT_STATES+1 cycles.
REQ-025 Read: ACCESS issues the SRAM read with hready_o=0; RDATA drives SRAM Q onto hrdata_o with hready_o=1.
REQ-026 Read data phase length is WAIT_STATES+2 cycles.
REQ-027 A new address phase accepted in the cycle hready_o=1 starts its data phase immediately, giving back-to-back transfers with no idle gap.
REQ-028 Write followed by a read of the same word returns the written bytes merged with the unchanged bytes.
REQ-029 hrdata_o holds its last value outside RDATA.
REQ-030 Byte lanes are little-endian; byte n of a word occupies hwdata_i[8n+7:8n].

Reset
REQ-031 While hreset_i=1: FSM enters IDLE, hready_o=1, hresp_o=0, hrdata_o=0, no SRAM write is issued.
REQ-032 Reset asserted mid-transfer aborts the transfer; a pending write is not committed. SRAM contents are not cleared.

Structure
REQ-033 Package ahb_pkg holds the htrans/hsize/hresp encodings and the FSM state enum.
REQ-034 The SRAM is a sub-module sram_sp_be: single-port, synchronous read, per-byte write enables, parametrised by DATA_WIDTH and ADDR_WIDTH.

Verification
REQ-035 WAIT_STATES=0: write word 0xDEADBEEF to BASE_ADDR, then read it -> hready_o low 0 cycles on write and 1 cycle on read; hrdata_o=0xDEADBEEF, hresp_o=0.
REQ-036 Byte write 0xAA (hsize=0) to BASE_ADDR+3 over 0x11223344, then read the word -> 0xAA223344.
REQ-037 Read at BASE_ADDR+2 with hsize=2 (misaligned), and a read at BASE_ADDR-4 (out of range) -> each gives ERR1 then ERR2, hresp_o=1 for 2 cycles, memory unchanged.
REQ-038 WAIT_STATES=2: back-to-back NONSEQ write then read -> write stall 2 cycles, read stall 3 cycles, correct data returned, no gap between transfers.
REQ-039 hreset_i pulsed in the WAIT cycle of a write of 0x12345678 over 0 -> outputs return to reset values; a subsequent read returns 0.
REQ-040 IDLE and BUSY transfers with hsel_i=1 -> hready_o=1, hresp_o=0 every cycle, no SRAM enable.
